bcd_time_keeper: RTL
====================

// Module: bcd_time_keeper
// PURPOSE
//  Time-of-day source for the VGA clock display: divides the pixel clock to a 1 Hz
//  tick and keeps hours:minutes:seconds as a 24 h BCD cascade. Three push-buttons
//  (synchronised, debounced, edge-detected here) set the time. Directly feeds the
//  digit fields consumed by the display/font stage; runs in the px_clk domain.
// PARAMETERS
//  CLK_HZ       31_500_000  clk cycles per second (prescaler terminal count + 1)
//  DEBOUNCE_CYC 315_000     cycles a synced button must be stable to be accepted
//  INIT_HRS_D   1           hrs_d loaded on reset (0..2)
//  INIT_HRS_U   1           hrs_u loaded on reset (0..9; INIT_HRS_D==2 -> 0..3)
//  INIT_MIN_D   5           min_d loaded on reset (0..5)
//  INIT_MIN_U   7           min_u loaded on reset (0..9)
// PORTS
//  clk       in   1  pixel clock (px_clk); all logic on rising edge
//  reset     in   1  synchronous, active-high
//  btn_hrs   in   1  async raw button, active-high: advance hours
//  btn_min   in   1  async raw button, active-high: advance minutes
//  btn_sec   in   1  async raw button, active-high: zero seconds
//  hrs_d     out  2  hours tens, BCD 0..2
//  hrs_u     out  4  hours units, BCD 0..9
//  min_d     out  3  minutes tens, 0..5
//  min_u     out  4  minutes units, 0..9
//  sec_d     out  3  seconds tens, 0..5
//  sec_u     out  4  seconds units, 0..9
//  sec_tick  out  1  one-cycle pulse in the cycle the seconds field advances
// BEHAVIOUR
//  Reset: digits <= INIT_* (sec = 00), prescaler <= 0, sec_tick <= 0, pending <= 0,
//   sync/debounce state cleared (debounced level 0, counters 0). Reset wins over all.
//  Prescaler: $clog2(CLK_HZ)-bit counter 0..CLK_HZ-1; at CLK_HZ-1 wraps to 0 and
//   raises tick_req that cycle. Digits change on the edge after tick_req (1-cycle latency).
//  Digits are registered; never hold an illegal value (sec_u/min_u/hrs_u never reach 10).
//  Cascade on tick (same edge, no intermediate states): sec_u 9->0 carries to sec_d;
//   sec_d 5->0 carries to min_u; min_u 9->0 -> min_d; min_d 5->0 -> hrs_u;
//   hrs_u 9->0 -> hrs_d; 23:59:59 -> 00:00:00. sec_tick=1 in the cycle digits update.
//  Buttons: 2-flop synchroniser -> debounce counter (restart on any change of synced
//   level; accept new level when count reaches DEBOUNCE_CYC-1) -> rising-edge detect
//   of accepted level = one adj pulse per press. Release never produces a pulse.
//  Adjust actions (no carry to neighbouring fields):
//   adj_hrs: hours +1, 23 -> 00; minutes/seconds untouched.
//   adj_min: minutes +1, 59 -> 00; hours untouched.
//   adj_sec: seconds <= 00 and prescaler <= 0 (re-phases the second).
//  Multiple adj pulses in one cycle: all applied (fields are disjoint).
//  Tick vs adjust same cycle: adjust applied; tick held in pending flag and the
//   cascade applied on the next cycle (sec_tick then). Exception: adj_sec discards the
//   coincident tick (pending not set). Pending with a new adjust: deferred again.
//  Button held indefinitely: exactly one pulse; no auto-repeat.
//  INIT_* out of range is a configuration error (elaboration $error).
// TESTING (CLK_HZ=10, DEBOUNCE_CYC=4 unless stated)
//  Reset for 3 cycles -> 11:57:00, sec_tick=0; first sec_tick 10 cycles after release,
//   then every 10 cycles; sec_u 0->1 same cycle as sec_tick.
//  Run from INIT 23:59 to 23:59:59 -> next tick gives 00:00:00 in one edge; check
//   9->0 carries at 00:00:09, 00:09:59, 09:59:59 likewise.
//  btn_min high 20 cycles at 11:59:30 -> 11:00:30 exactly once; glitch of 2 cycles
//   -> no change; btn_hrs at 23:xx -> 00:xx, minutes unchanged.
//  adj_min pulse forced in same cycle as tick at 10:20:09 -> 10:21:09 that edge,
//   then 10:21:10 with sec_tick next cycle; adj_sec coincident with tick -> :00,
//   next tick 10 cycles later.
//  Assert reset mid-debounce and mid-prescale -> INIT time, no spurious adj pulse
//   after release even if button still held (press accepted only after debounce).
//  Random buttons + free run 10^5 cycles vs reference model; digits always legal.

Source files
------------

// File: rtl/bcd_time_keeper.sv
// 24 h BCD time-of-day keeper: prescales clk to a 1 Hz tick, cascades hh:mm:ss and
// applies debounced push-button adjustments (hours +1, minutes +1, seconds zero).
module bcd_time_keeper #(
    parameter int CLK_HZ       = 31_500_000,
    parameter int DEBOUNCE_CYC = 315_000,
    parameter int INIT_HRS_D   = 1,
    parameter int INIT_HRS_U   = 1,
    parameter int INIT_MIN_D   = 5,
    parameter int INIT_MIN_U   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_hrs,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [1:0] hrs_d,
    output logic [3:0] hrs_u,
    output logic [2:0] min_d,
    output logic [3:0] min_u,
    output logic [2:0] sec_d,
    output logic [3:0] sec_u,
    output logic       sec_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

    generate
        if (INIT_HRS_D < 0 || INIT_HRS_D > 2 || INIT_HRS_U < 0 || INIT_HRS_U > 9 ||
            (INIT_HRS_D == 2 && INIT_HRS_U > 3) || INIT_MIN_D < 0 || INIT_MIN_D > 5 ||
            INIT_MIN_U < 0 || INIT_MIN_U > 9) begin : g_bad_init
            $error("bcd_time_keeper: INIT_* time out of range");
        end
    endgenerate

    // Bit 0 = hours, bit 1 = minutes, bit 2 = seconds
    logic [2:0] btn_raw;
    logic [2:0] adj;
    assign btn_raw = {btn_sec, btn_min, btn_hrs};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_q;
            logic          sync2_q;
            logic          level_q;
            logic          level_prev_q;
            logic [DW-1:0] deb_cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    deb_cnt_q    <= '0;
                end else begin
                    sync1_q      <= btn_raw[gi];
                    sync2_q      <= sync1_q;
                    level_prev_q <= level_q;
                    // Counter only runs while the synced input disagrees with the accepted level
                    if (sync2_q == level_q) begin
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        level_q   <= sync2_q;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
            end

            assign adj[gi] = level_q & ~level_prev_q;
        end
    endgenerate

    function automatic logic [5:0] hrs_inc(input logic [1:0] d, input logic [3:0] u);
        if (d == 2'd2 && u == 4'd3) return 6'd0;
        else if (u == 4'd9)         return {d + 2'd1, 4'd0};
        else                        return {d, u + 4'd1};
    endfunction

    function automatic logic [6:0] min_inc(input logic [2:0] d, input logic [3:0] u);
        if (u != 4'd9)      return {d, u + 4'd1};
        else if (d != 3'd5) return {d + 3'd1, 4'd0};
        else                return 7'd0;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic          pending_q, pending_d;
    logic          sec_tick_q, sec_tick_d;
    logic [1:0]    hrs_d_q, hrs_d_d;
    logic [3:0]    hrs_u_q, hrs_u_d;
    logic [2:0]    min_d_q, min_d_d;
    logic [3:0]    min_u_q, min_u_d;
    logic [2:0]    sec_d_q, sec_d_d;
    logic [3:0]    sec_u_q, sec_u_d;
    logic          tick_req;
    logic          tick_due;

    assign tick_req = (pre_q == PRE_LAST);
    assign tick_due = tick_req | pending_q;

    always_comb begin
        pre_d      = tick_req ? '0 : pre_q + 1'b1;
        pending_d  = pending_q;
        sec_tick_d = 1'b0;
        hrs_d_d    = hrs_d_q;
        hrs_u_d    = hrs_u_q;
        min_d_d    = min_d_q;
        min_u_d    = min_u_q;
        sec_d_d    = sec_d_q;
        sec_u_d    = sec_u_q;
        if (|adj) begin
            if (adj[0]) {hrs_d_d, hrs_u_d} = hrs_inc(hrs_d_q, hrs_u_q);
            if (adj[1]) {min_d_d, min_u_d} = min_inc(min_d_q, min_u_q);
            if (adj[2]) begin
                sec_d_d = '0;
                sec_u_d = '0;
                pre_d   = '0;
            end
            // A tick that meets an adjustment is replayed next cycle, unless seconds were re-phased
            pending_d = tick_due & ~adj[2];
        end else if (tick_due) begin
            sec_tick_d = 1'b1;
            pending_d  = 1'b0;
            if (sec_u_q != 4'd9) begin
                sec_u_d = sec_u_q + 4'd1;
            end else begin
                sec_u_d = 4'd0;
                if (sec_d_q != 3'd5) begin
                    sec_d_d = sec_d_q + 3'd1;
                end else begin
                    sec_d_d = 3'd0;
                    {min_d_d, min_u_d} = min_inc(min_d_q, min_u_q);
                    if (min_d_q == 3'd5 && min_u_q == 4'd9)
                        {hrs_d_d, hrs_u_d} = hrs_inc(hrs_d_q, hrs_u_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            pending_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            hrs_d_q    <= 2'(INIT_HRS_D);
            hrs_u_q    <= 4'(INIT_HRS_U);
            min_d_q    <= 3'(INIT_MIN_D);
            min_u_q    <= 4'(INIT_MIN_U);
            sec_d_q    <= 3'd0;
            sec_u_q    <= 4'd0;
        end else begin
            pre_q      <= pre_d;
            pending_q  <= pending_d;
            sec_tick_q <= sec_tick_d;
            hrs_d_q    <= hrs_d_d;
            hrs_u_q    <= hrs_u_d;
            min_d_q    <= min_d_d;
            min_u_q    <= min_u_d;
            sec_d_q    <= sec_d_d;
            sec_u_q    <= sec_u_d;
        end
    end

    assign hrs_d    = hrs_d_q;
    assign hrs_u    = hrs_u_q;
    assign min_d    = min_d_q;
    assign min_u    = min_u_q;
    assign sec_d    = sec_d_q;
    assign sec_u    = sec_u_q;
    assign sec_tick = sec_tick_q;

endmodule
